// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encoding, cell latency
// and the single-bit full-subtractor equation.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_DONE  = 2'd2
  } state_e;

  // Bits consumed by the subtractor cell on each clock edge.
  localparam int unsigned S_ONE = 32'd1;

  // Returns {borrow, diff} for x - y - bw.
  function automatic logic [1:0] fsub_bit(input logic x, input logic y, input logic bw);
    logic d;
    logic bo;
    d  = x ^ y ^ bw;
    bo = (~x & y) | (~x & bw) | (y & bw);
    return {bo, d};
  endfunction

endpackage

// File: rtl/serial_subtractor_full_sub.sv
// Combinational 1-bit full-subtractor cell; the only arithmetic in the
// serial datapath.
module full_subtractor
  import serial_subtractor_pkg::*;
(
  input  logic x_i,
  input  logic y_i,
  input  logic bin_i,
  output logic diff_o,
  output logic borrow_o
);

  logic [1:0] cell_s;

  // Evaluate the subtractor cell for the current bit.
  always_comb begin
    cell_s = fsub_bit(x_i, y_i, bin_i);
  end

  assign diff_o   = cell_s[0];
  assign borrow_o = cell_s[1];

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: diff = a - b - bin, LSB first, one bit per
// clock through a single full-subtractor cell, with a start/done handshake.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CNT_W = $clog2(WIDTH);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - S_ONE);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-2:0] work_q, work_d;
  logic             bw_q, bw_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] diff_q, diff_d;
  logic             bo_q, bo_d;

  logic             cell_d_s;
  logic             cell_bo_s;
  logic [WIDTH-1:0] res_s;

  full_subtractor u_cell (
    .x_i     (a_q[0]),
    .y_i     (b_q[0]),
    .bin_i   (bw_q),
    .diff_o  (cell_d_s),
    .borrow_o(cell_bo_s)
  );

  // New bit enters at the top; after the final edge res_s is the whole result.
  assign res_s = {cell_d_s, work_q};

  // Next-state and datapath update; start is only examined in IDLE and DONE.
  always_comb begin
    state_d = state_q;
    a_d     = a_q;
    b_d     = b_q;
    work_d  = work_q;
    bw_d    = bw_q;
    cnt_d   = cnt_q;
    diff_d  = diff_q;
    bo_d    = bo_q;
    case (state_q)
      S_IDLE, S_DONE: begin
        if (start) begin
          a_d     = a;
          b_d     = b;
          bw_d    = bin;
          work_d  = '0;
          cnt_d   = '0;
          state_d = S_SHIFT;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_SHIFT: begin
        a_d    = a_q >> 1;
        b_d    = b_q >> 1;
        work_d = res_s[WIDTH-1:1];
        bw_d   = cell_bo_s;
        if (cnt_q == CNT_LAST) begin
          diff_d  = res_s;
          bo_d    = cell_bo_s;
          state_d = S_DONE;
        end else begin
          cnt_d   = cnt_q + CNT_W'(1);
          state_d = S_SHIFT;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and datapath registers; reset aborts any operation in flight.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      work_q  <= '0;
      bw_q    <= 1'b0;
      cnt_q   <= '0;
      diff_q  <= '0;
      bo_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      work_q  <= work_d;
      bw_q    <= bw_d;
      cnt_q   <= cnt_d;
      diff_q  <= diff_d;
      bo_q    <= bo_d;
    end
  end

  assign busy       = (state_q == S_SHIFT);
  assign done       = (state_q == S_DONE);
  assign diff       = diff_q;
  assign borrow_out = bo_q;

endmodule
